fft_pipe_ctrl: RTL and testbench

FFT_PIPE_CTRL -- requirements
Module: fft_pipe_ctrl

---
 rtl/fft_pkg.sv | 30 +++
 rtl/fft_wren_shift.sv | 48 ++++
 rtl/fft_pipe_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_fft_pipe_ctrl.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// ---------------------------------------------------------------------------
// fft_pkg -- shared definitions for the FFT pipeline controller.
//
// Holds the controller state encoding, the default pipeline dimensions and a
// small helper for sizing counters. Imported by fft_wren_shift and
// fft_pipe_ctrl.
// ---------------------------------------------------------------------------
package fft_pkg;

  // Controller states. The encoding is fixed because other blocks and debug
  // tooling decode the raw state value.
  typedef enum logic [2:0] {
    IDLE  = 3'b000,
    LOAD  = 3'b001,
    DRAIN = 3'b010,
    DONE  = 3'b011,
    ERROR = 3'b100
  } state_t;

  // Default pipeline dimensions.
  localparam int DEF_NUMSTAGES    = 8;
  localparam int DEF_NUMSAMPLES   = 256;
  localparam int DEF_TOTALSAMPLES = 10240;

  // Width of a counter that must hold values 0..n-1, never narrower than 1.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fft_wren_shift.sv
// ---------------------------------------------------------------------------
// fft_wren_shift -- per-stage write-enable delay line.
//
// Bit 0 of wr_en is the stage-0 write enable supplied on din; each higher bit
// is the previous bit delayed by one clock, so stage k writes exactly k cycles
// after stage 0.
//
// Ports
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset, empties the line
//   clr    in   synchronous flush of every delayed bit (abandoning a run)
//   din    in   stage-0 write enable
//   wr_en  out  NUMSTAGES-bit write-enable vector, bit k to stage k
// ---------------------------------------------------------------------------
module fft_wren_shift
  import fft_pkg::*;
#(
  parameter int NUMSTAGES = DEF_NUMSTAGES
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 din,
  output logic [NUMSTAGES-1:0] wr_en
);

  localparam int TW = NUMSTAGES - 1;

  // taps[j] is the write enable of stage j+1.
  logic [TW-1:0] taps;

  // NOTE: the delay line is reset even though it only carries enables: a
  // stale bit left over from an abandoned run would fire a write into a stage
  // of the next run. State is updated with non-blocking assignments so every
  // tap samples its neighbour's pre-edge value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      taps <= '0;
    end else if (clr) begin
      taps <= '0;
    end else begin
      taps <= (taps << 1) | TW'(din);
    end
  end

  assign wr_en = {taps, din};

endmodule

// File: rtl/fft_pipe_ctrl.sv
// ---------------------------------------------------------------------------
// fft_pipe_ctrl -- sequencer for a chain of NUMSTAGES fft_stage instances.
//
// A run loads sample beats into stage 0 until the loader reports the last
// beat, then drains the pipeline until every stage has written its last beat.
// Beats leaving the last stage are counted into frames.
//
// Optional feature: define FFT_PIPE_CTRL_ERR_EN to honour init_error. When
// defined, init_error during LOAD aborts the run into ERROR and raises the
// sticky error flag. When undefined, init_error is ignored, ERROR is never
// entered and error is tied low.
//
// Ports
//   clk         in   rising-edge clock
//   rst_n       in   asynchronous active-low reset
//   start       in   level request to begin a run (sampled in IDLE; its
//                    release also lets DONE/ERROR return to IDLE)
//   ld_done     in   loader delivered its last sample beat
//   init_error  in   loader initialisation failed
//   ld_data     out  loader enable / stage-0 input mux select
//   en          out  global stage enable
//   wr_en       out  per-stage write enable, bit k to stage k
//   busy        out  controller not in IDLE
//   frame_cnt   out  frames completed at the last stage, saturating
//   done        out  one-cycle pulse as the run completes
//   error       out  sticky initialisation-error flag
// ---------------------------------------------------------------------------
module fft_pipe_ctrl
  import fft_pkg::*;
#(
  parameter int NUMSTAGES    = DEF_NUMSTAGES,
  parameter int NUMSAMPLES   = DEF_NUMSAMPLES,
  parameter int TOTALSAMPLES = DEF_TOTALSAMPLES
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  logic                                       start,
  input  logic                                       ld_done,
  input  logic                                       init_error,
  output logic                                       ld_data,
  output logic                                       en,
  output logic [NUMSTAGES-1:0]                       wr_en,
  output logic                                       busy,
  output logic [$clog2(TOTALSAMPLES/NUMSAMPLES):0]   frame_cnt,
  output logic                                       done,
  output logic                                       error
);

  localparam int BPF = NUMSAMPLES / 4;           // beats per frame
  localparam int FPR = TOTALSAMPLES / NUMSAMPLES; // frames per run
  localparam int BW  = cnt_width(BPF);
  localparam int FW  = $clog2(FPR) + 1;

  localparam logic [BW-1:0] BEAT_LAST = BW'(BPF - 1);
  localparam logic [FW-1:0] FRAME_MAX = FW'(FPR);

  state_t        state;
  state_t        state_next;
  logic          wr_en0;
  logic          flush;
  logic          start_run;
  logic [BW-1:0] beat_cnt;

  // ------------------------------------------------------------------------
  // State register
  // ------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Stage 0 writes on every LOAD cycle. Kept out of the FSM block below
  // because that block also inspects the delayed enables derived from it.
  assign wr_en0 = (state == LOAD);

  // ------------------------------------------------------------------------
  // Next state and Moore outputs
  // ------------------------------------------------------------------------
  // NOTE: every signal driven here is given a default before the case, so no
  // path through the block leaves a value unassigned and no latch is formed.
  always_comb begin
    state_next = state;
    ld_data    = 1'b0;
    en         = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;

    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_next = LOAD;
      end

      LOAD: begin
        ld_data = 1'b1;
        en      = 1'b1;
        if (ld_done) state_next = DRAIN;
`ifdef FFT_PIPE_CTRL_ERR_EN
        // Evaluated last so it overrides a simultaneous ld_done.
        if (init_error) state_next = ERROR;
`endif
      end

      DRAIN: begin
        en = 1'b1;
        // Stage 0 stopped on entry, so the vector empties exactly NUMSTAGES
        // cycles after the last load beat; that is the completion cycle.
        if (wr_en == '0) begin
          done       = 1'b1;
          state_next = DONE;
        end
      end

      DONE: begin
        // Holding start keeps us here so a level request cannot retrigger.
        if (!start) state_next = IDLE;
      end

      ERROR: begin
        if (!start) state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign start_run = (state == IDLE) && start;

  // ------------------------------------------------------------------------
  // Optional initialisation-error handling
  // ------------------------------------------------------------------------
`ifdef FFT_PIPE_CTRL_ERR_EN
  logic error_q;

  // Abandoning a load must also silence every stage still holding a beat.
  assign flush = (state == LOAD) && init_error;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      error_q <= 1'b0;
    end else if (start_run) begin
      error_q <= 1'b0;
    end else if (flush) begin
      error_q <= 1'b1;
    end
  end

  assign error = error_q;
`else
  logic unused_init_error;

  assign unused_init_error = init_error;
  assign flush             = 1'b0;
  assign error             = 1'b0;
`endif

  // ------------------------------------------------------------------------
  // Write-enable delay line
  // ------------------------------------------------------------------------
  fft_wren_shift #(
    .NUMSTAGES (NUMSTAGES)
  ) u_wren_shift (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (flush),
    .din   (wr_en0),
    .wr_en (wr_en)
  );

  // ------------------------------------------------------------------------
  // Beat / frame counters at the last stage output
  // ------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt  <= '0;
      frame_cnt <= '0;
    end else if (start_run) begin
      beat_cnt  <= '0;
      frame_cnt <= '0;
    end else if (wr_en[NUMSTAGES-1]) begin
      if (beat_cnt == BEAT_LAST) begin
        beat_cnt <= '0;
        if (frame_cnt < FRAME_MAX) frame_cnt <= frame_cnt + FW'(1);
      end else begin
        beat_cnt <= beat_cnt + BW'(1);
      end
    end
  end

endmodule

// File: tb/tb_fft_pipe_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fft_pipe_ctrl -- self-checking bench for fft_pipe_ctrl.
//
// Every cycle of a run is compared against a timeline computed from the run
// length: stage k writes during cycles [k, k+n) counted from the first LOAD
// cycle, the run completes NUMSTAGES cycles after the last load beat, and
// frames are whole groups of BPF beats that have left the last stage.
// Honours FFT_PIPE_CTRL_ERR_EN for the initialisation-error sequence.
// ---------------------------------------------------------------------------
module tb_fft_pipe_ctrl;

  localparam int NS  = 8;
  localparam int NSA = 256;
  localparam int TOT = 10240;
  localparam int BPF = NSA / 4;
  localparam int FPR = TOT / NSA;
  localparam int FW  = $clog2(FPR) + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          ld_done;
  logic          init_error;
  logic          ld_data;
  logic          en;
  logic [NS-1:0] wr_en;
  logic          busy;
  logic [FW-1:0] frame_cnt;
  logic          done;
  logic          error;

  int n_checks = 0;
  int n_err    = 0;
  int last_frames = 0;

  fft_pipe_ctrl #(
    .NUMSTAGES    (NS),
    .NUMSAMPLES   (NSA),
    .TOTALSAMPLES (TOT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .ld_done    (ld_done),
    .init_error (init_error),
    .ld_data    (ld_data),
    .en         (en),
    .wr_en      (wr_en),
    .busy       (busy),
    .frame_cnt  (frame_cnt),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  typedef struct {
    int n;
    int hold;
    int exp_frames;
    bit wiggle;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Layout: {ld_data, en, busy, done, error, frame_cnt, wr_en}
  function automatic logic [31:0] obs();
    return 32'({ld_data, en, busy, done, error, frame_cnt, wr_en});
  endfunction

  function automatic int frames_of(input int beats);
    int f;
    f = beats / BPF;
    if (f > FPR) f = FPR;
    return f;
  endfunction

  function automatic logic [31:0] idle_exp(input int f, input bit err);
    return 32'({5'b00000 | 5'(err), 7'(f), 8'h00});
  endfunction

  // Expected outputs in cycle t of a run of n load beats; t=0 is the first
  // LOAD cycle and the controller is busy through cycle busy_end.
  function automatic logic [31:0] model(input int t, input int n, input int busy_end);
    logic [NS-1:0] w;
    int c;
    for (int k = 0; k < NS; k++) w[k] = (t >= k) && (t < k + n);
    c = t - (NS - 1);
    if (c < 0) c = 0;
    if (c > n) c = n;
    return 32'({(t < n), (t < n + NS), (t <= busy_end), (t == n + NS - 1), 1'b0,
                7'(frames_of(c)), w});
  endfunction

  // Full run: called on a negedge in IDLE, returns on a negedge in IDLE.
  task automatic do_run(input int n, input int hold, input int exp_frames,
                        input bit wiggle, input bit with_ierr);
    int t_end;
    int dones;
    int fr_at_done;
    t_end      = n + NS + hold;
    dones      = 0;
    fr_at_done = -1;
    start      = 1'b1;
    ld_done    = 1'b0;
    @(negedge clk);
    for (int t = 0; t <= t_end + 1; t++) begin
      check($sformatf("run n=%0d t=%0d", n, t), obs(), model(t, n, t_end));
      if (done) begin
        dones++;
        fr_at_done = int'(frame_cnt);
      end
      ld_done    = (t == n - 1);
      init_error = with_ierr && (t == n - 1);
      if (t < n + NS) start = wiggle ? 1'($urandom_range(0, 1)) : 1'b1;
      else            start = (t < t_end);
      @(negedge clk);
    end
    ld_done    = 1'b0;
    init_error = 1'b0;
    check($sformatf("done_pulses n=%0d", n), 32'(dones), 32'd1);
    check($sformatf("frames_at_done n=%0d", n), 32'(fr_at_done), 32'(exp_frames));
    last_frames = exp_frames;
  endtask

  // Start a run, stop it with an asynchronous reset in cycle stop_t.
  task automatic abort_run(input int n, input int stop_t);
    start   = 1'b1;
    ld_done = 1'b0;
    @(negedge clk);
    for (int t = 0; t < stop_t; t++) begin
      check($sformatf("abort n=%0d t=%0d", n, t), obs(), model(t, n, 1 << 30));
      ld_done = (t == n - 1);
      @(negedge clk);
    end
    ld_done = 1'b0;
    #2 rst_n = 1'b0;
    #1 check($sformatf("async_reset t=%0d", stop_t), obs(), 32'd0);
    start = 1'b0;
    @(negedge clk);
    check("reset_held", obs(), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_idle", obs(), 32'd0);
    last_frames = 0;
  endtask

  initial begin
    vecs[0] = '{2560, 0, 40, 1'b0};
    vecs[1] = '{1,    0, 0,  1'b0};
    vecs[2] = '{63,   2, 0,  1'b1};
    vecs[3] = '{64,   0, 1,  1'b0};
    vecs[4] = '{65,   3, 1,  1'b1};
    vecs[5] = '{128,  1, 2,  1'b0};
    vecs[6] = '{2700, 0, 40, 1'b0};
    vecs[7] = '{2560, 4, 40, 1'b1};
    vecs[8] = '{10,   4, 0,  1'b1};

    rst_n      = 1'b0;
    start      = 1'b0;
    ld_done    = 1'b0;
    init_error = 1'b0;
    @(negedge clk);
    check("reset_state", obs(), 32'd0);
    start = 1'b1;  // must be ignored while reset is held
    @(negedge clk);
    check("reset_ignores_start", obs(), 32'd0);
    start = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_after_reset", obs(), idle_exp(0, 1'b0));

    // Table-driven runs.
    for (int i = 0; i < 9; i++) begin
      do_run(vecs[i].n, vecs[i].hold, vecs[i].exp_frames, vecs[i].wiggle, 1'b0);
      check($sformatf("idle_after_vec%0d", i), obs(), idle_exp(last_frames, 1'b0));
    end

    // Reset mid-LOAD, then a full clean run.
    abort_run(2560, 100);
    do_run(2560, 0, 40, 1'b0, 1'b0);

    // Reset mid-DRAIN, then a short run.
    abort_run(20, 24);
    do_run(64, 1, 1, 1'b0, 1'b0);

    // Initialisation error coinciding with the last load beat.
`ifdef FFT_PIPE_CTRL_ERR_EN
    begin
      int dones;
      dones   = 0;
      start   = 1'b1;
      @(negedge clk);
      for (int t = 0; t < 10; t++) begin
        check($sformatf("err_load t=%0d", t), obs(), model(t, 10, 1 << 30));
        ld_done    = (t == 9);
        init_error = (t == 9);
        @(negedge clk);
      end
      ld_done    = 1'b0;
      init_error = 1'b0;
      for (int t = 0; t < 4; t++) begin
        check($sformatf("error_state c=%0d", t), obs(), 32'({5'b00101, 7'd0, 8'h00}));
        if (done) dones++;
        start = (t < 3);
        @(negedge clk);
      end
      check("error_sticky_idle", obs(), idle_exp(0, 1'b1));
      check("error_no_done", 32'(dones), 32'd0);
      last_frames = 0;
      do_run(64, 0, 1, 1'b0, 1'b0);
    end
`else
    do_run(10, 0, 0, 1'b0, 1'b1);
    check("no_error_flag", 32'(error), 32'd0);
`endif

    // Randomised runs with idle gaps.
    for (int r = 0; r < 8; r++) begin
      int n;
      int gap;
      n   = $urandom_range(1, 300);
      gap = $urandom_range(0, 3);
      do_run(n, $urandom_range(0, 3), frames_of(n), 1'($urandom_range(0, 1)), 1'b0);
      for (int g = 0; g < gap; g++) begin
        check($sformatf("idle_gap r=%0d g=%0d", r, g), obs(), idle_exp(last_frames, 1'b0));
        @(negedge clk);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
